// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage inputs from the hazard/decode side and the per-stage control outputs.
// Jump_o / LinkSel_o exist only when CTRL_PIPE_JUMP_EN is defined.
interface ctrl_pipe_if #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    Op_i;
  logic               Valid_i;
  logic               NoOp_i;
  logic               Stall_i;
  logic               Flush_i;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic               ALUSrc_o;
  logic               Branch_o;
  logic               Illegal_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               RegWrite_o;
  logic               MemtoReg_o;
  logic               Retire_o;
`ifdef CTRL_PIPE_JUMP_EN
  logic               Jump_o;
  logic               LinkSel_o;

  modport master (
    output Op_i, Valid_i, NoOp_i, Stall_i, Flush_i,
    input  ALUOp_o, ALUSrc_o, Branch_o, Illegal_o, MemRead_o, MemWrite_o,
           RegWrite_o, MemtoReg_o, Retire_o, Jump_o, LinkSel_o
  );
  modport slave (
    input  Op_i, Valid_i, NoOp_i, Stall_i, Flush_i,
    output ALUOp_o, ALUSrc_o, Branch_o, Illegal_o, MemRead_o, MemWrite_o,
           RegWrite_o, MemtoReg_o, Retire_o, Jump_o, LinkSel_o
  );
`else
  modport master (
    output Op_i, Valid_i, NoOp_i, Stall_i, Flush_i,
    input  ALUOp_o, ALUSrc_o, Branch_o, Illegal_o, MemRead_o, MemWrite_o,
           RegWrite_o, MemtoReg_o, Retire_o
  );
  modport slave (
    input  Op_i, Valid_i, NoOp_i, Stall_i, Flush_i,
    output ALUOp_o, ALUSrc_o, Branch_o, Illegal_o, MemRead_o, MemWrite_o,
           RegWrite_o, MemtoReg_o, Retire_o
  );
`endif
endinterface

// File: rtl/ctrl_pipe.sv
// ID-stage opcode decoder feeding registered ID/EX, EX/MEM and MEM/WB control stages.
// Optional JAL/JALR support is enabled with the CTRL_PIPE_JUMP_EN macro.
module ctrl_pipe #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  ctrl_pipe_if.slave bus
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I    = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);
`ifdef CTRL_PIPE_JUMP_EN
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(7'b1100111);
`endif

  // Each stage register keeps only the fields that stage or a later one consumes.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               branch;
    logic               illegal;
`ifdef CTRL_PIPE_JUMP_EN
    logic               jump;
    logic               link_sel;
`endif
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               valid;
  } ex_t;

  typedef struct packed {
`ifdef CTRL_PIPE_JUMP_EN
    logic link_sel;
`endif
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic valid;
  } mem_t;

  typedef struct packed {
`ifdef CTRL_PIPE_JUMP_EN
    logic link_sel;
`endif
    logic reg_write;
    logic mem_to_reg;
    logic valid;
  } wb_t;

  ex_t  dec;
  ex_t  ex_q;
  mem_t mem_q;
  wb_t  wb_q;

  always_comb begin
    // NOTE: defaulting the whole bundle first keeps every path assigned, so no latch is inferred.
    dec = '0;
    if (bus.Valid_i && !bus.NoOp_i) begin
      dec.valid = 1'b1;
      case (bus.Op_i)
        OP_R:   begin dec.alu_op = ALUOP_W'(2'b10); dec.reg_write = 1'b1; end
        OP_I:   begin dec.alu_op = ALUOP_W'(2'b11); dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
        OP_LW:  begin
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.mem_read   = 1'b1;
        end
        OP_SW:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
        OP_BEQ: begin dec.alu_op = ALUOP_W'(2'b01); dec.branch = 1'b1; end
`ifdef CTRL_PIPE_JUMP_EN
        OP_JAL:  begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.link_sel = 1'b1; end
        OP_JALR: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.link_sel  = 1'b1;
        end
`endif
        // Unknown opcode: control stays all-zero, only the illegal flag survives.
        default: begin dec.valid = 1'b0; dec.illegal = 1'b1; end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all three stages shift on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.Stall_i) begin
      ex_q <= bus.Flush_i ? '0 : dec;

      mem_q.mem_read   <= ex_q.mem_read;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_to_reg <= ex_q.mem_to_reg;
      mem_q.valid      <= ex_q.valid;

      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.mem_to_reg  <= mem_q.mem_to_reg;
      wb_q.valid       <= mem_q.valid;
`ifdef CTRL_PIPE_JUMP_EN
      mem_q.link_sel   <= ex_q.link_sel;
      wb_q.link_sel    <= mem_q.link_sel;
`endif
    end
  end

  assign bus.ALUOp_o    = ex_q.alu_op;
  assign bus.ALUSrc_o   = ex_q.alu_src;
  assign bus.Branch_o   = ex_q.branch;
  assign bus.Illegal_o  = ex_q.illegal;
  assign bus.MemRead_o  = mem_q.mem_read;
  assign bus.MemWrite_o = mem_q.mem_write;
  assign bus.RegWrite_o = wb_q.reg_write;
  assign bus.MemtoReg_o = wb_q.mem_to_reg;
  assign bus.Retire_o   = wb_q.valid;
`ifdef CTRL_PIPE_JUMP_EN
  assign bus.Jump_o     = ex_q.jump;
  assign bus.LinkSel_o  = wb_q.link_sel;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic against an
// instruction-level pipeline model.
module tb_ctrl_pipe;

  typedef enum {K_NONE, K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL, K_JALR, K_ILL} kind_e;

  typedef struct {
    logic [1:0] alu_op;
    logic alu_src, reg_write, mem_to_reg, mem_read, mem_write, branch, jump, link_sel;
  } exp_t;

  localparam logic [6:0] C_R    = 7'b0110011;
  localparam logic [6:0] C_I    = 7'b0010011;
  localparam logic [6:0] C_LW   = 7'b0000011;
  localparam logic [6:0] C_SW   = 7'b0100011;
  localparam logic [6:0] C_BEQ  = 7'b1100011;
  localparam logic [6:0] C_JAL  = 7'b1101111;
  localparam logic [6:0] C_JALR = 7'b1100111;
  localparam logic [6:0] C_BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.OP_W(7), .ALUOP_W(2)) bus ();
  ctrl_pipe #(.OP_W(7), .ALUOP_W(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int memread_cnt = 0, memwrite_cnt = 0, regwrite_cnt = 0, retire_evt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction kind from the opcode table; bubbles and unknown opcodes are distinguished.
  function automatic kind_e classify(input logic [6:0] op, input logic v, input logic n);
    if (!v || n) return K_NONE;
    case (op)
      C_R:   return K_R;
      C_I:   return K_I;
      C_LW:  return K_LW;
      C_SW:  return K_SW;
      C_BEQ: return K_BEQ;
`ifdef CTRL_PIPE_JUMP_EN
      C_JAL:  return K_JAL;
      C_JALR: return K_JALR;
`endif
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t lookup(input kind_e k);
    exp_t e = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    case (k)
      K_R:    begin e.alu_op = 2'b10; e.reg_write = 1'b1; end
      K_I:    begin e.alu_op = 2'b11; e.alu_src = 1'b1; e.reg_write = 1'b1; end
      K_LW:   begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.mem_read = 1'b1; end
      K_SW:   begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
      K_BEQ:  begin e.alu_op = 2'b01; e.branch = 1'b1; end
      K_JAL:  begin e.reg_write = 1'b1; e.jump = 1'b1; e.link_sel = 1'b1; end
      K_JALR: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.jump = 1'b1; e.link_sel = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Model: which instruction occupies EX, MEM and WB.
  kind_e slot [3] = '{K_NONE, K_NONE, K_NONE};
  logic  model_ready = 1'b0;
  logic  last_stall  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      slot        <= '{K_NONE, K_NONE, K_NONE};
      model_ready <= 1'b1;
    end else if (!bus.Stall_i) begin
      slot[0] <= bus.Flush_i ? K_NONE : classify(bus.Op_i, bus.Valid_i, bus.NoOp_i);
      slot[1] <= slot[0];
      slot[2] <= slot[1];
    end
    last_stall <= bus.Stall_i && !rst;
  end

  exp_t e_ex, e_mem, e_wb;
  always @(negedge clk) begin
    if (model_ready) begin
      e_ex  = lookup(slot[0]);
      e_mem = lookup(slot[1]);
      e_wb  = lookup(slot[2]);
      check("ex_alu_op",    8'(bus.ALUOp_o),    8'(e_ex.alu_op));
      check("ex_alu_src",   8'(bus.ALUSrc_o),   8'(e_ex.alu_src));
      check("ex_branch",    8'(bus.Branch_o),   8'(e_ex.branch));
      check("ex_illegal",   8'(bus.Illegal_o),  8'(slot[0] == K_ILL));
      check("mem_read",     8'(bus.MemRead_o),  8'(e_mem.mem_read));
      check("mem_write",    8'(bus.MemWrite_o), 8'(e_mem.mem_write));
      check("wb_reg_write", 8'(bus.RegWrite_o), 8'(e_wb.reg_write));
      check("wb_mem_to_reg",8'(bus.MemtoReg_o), 8'(e_wb.mem_to_reg));
      check("wb_retire",    8'(bus.Retire_o),   8'(slot[2] != K_NONE && slot[2] != K_ILL));
`ifdef CTRL_PIPE_JUMP_EN
      check("ex_jump",      8'(bus.Jump_o),     8'(e_ex.jump));
      check("wb_link_sel",  8'(bus.LinkSel_o),  8'(e_wb.link_sel));
`endif
      if (bus.MemRead_o)  memread_cnt++;
      if (bus.MemWrite_o) memwrite_cnt++;
      if (bus.RegWrite_o) regwrite_cnt++;
      if (bus.Retire_o && !last_stall) retire_evt++;
    end
  end

  // Drive one cycle of inputs, then return just after the sampling edge.
  task automatic drive(input logic [6:0] op, input logic v, input logic n,
                       input logic s, input logic f, input logic r);
    bus.Op_i = op; bus.Valid_i = v; bus.NoOp_i = n;
    bus.Stall_i = s; bus.Flush_i = f; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int base;
  logic [6:0] pool [8] = '{C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_JALR, C_BAD};

  initial begin
    // Reset with an R-type held on the inputs.
    drive(C_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(C_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_alu_op",    8'(bus.ALUOp_o),    8'h00);
    check("rst_reg_write", 8'(bus.RegWrite_o), 8'h00);
    check("rst_retire",    8'(bus.Retire_o),   8'h00);
    drive(C_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_ex_alu_op", 8'(bus.ALUOp_o), 8'h02);
    idle(2);
    check("lat_wb_reg_write", 8'(bus.RegWrite_o), 8'h01);
    check("lat_wb_retire",    8'(bus.Retire_o),   8'h01);
    idle(3);

    // Back-to-back LW, SW, BEQ, R, I.
    base = memread_cnt;
    drive(C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lw_ex_alu_src", 8'(bus.ALUSrc_o), 8'h01);
    drive(C_SW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lw_mem_read", 8'(bus.MemRead_o), 8'h01);
    drive(C_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sw_mem_write", 8'(bus.MemWrite_o), 8'h01);
    check("lw_wb_mem_to_reg", 8'(bus.MemtoReg_o), 8'h01);
    drive(C_R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(C_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("i_ex_alu_op", 8'(bus.ALUOp_o), 8'h03);
    idle(4);
    check("memread_once", 8'(memread_cnt - base), 8'h01);

    // LW followed by a three-cycle stall.
    base = retire_evt;
    drive(C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(C_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_ex_hold", 8'(bus.ALUSrc_o), 8'h01);
    drive(C_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(C_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_mem_idle", 8'(bus.MemRead_o), 8'h00);
    idle(4);
    check("stall_single_retire", 8'(retire_evt - base), 8'h01);

    // BEQ then flushed SW.
    base = memwrite_cnt;
    drive(C_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("beq_ex_branch", 8'(bus.Branch_o), 8'h01);
    drive(C_SW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_ex_bubble", 8'(bus.ALUSrc_o), 8'h00);
    idle(4);
    check("flush_no_memwrite", 8'(memwrite_cnt - base), 8'h00);

    // Bubble requested over an R-type.
    base = regwrite_cnt;
    drive(C_R, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("noop_ex_alu_op", 8'(bus.ALUOp_o), 8'h00);
    idle(4);
    check("noop_no_regwrite", 8'(regwrite_cnt - base), 8'h00);

    // Illegal opcode, valid and not valid.
    drive(C_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("illegal_set", 8'(bus.Illegal_o), 8'h01);
    drive(C_BAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("illegal_invalid", 8'(bus.Illegal_o), 8'h00);
    idle(4);

    // Stall and flush together, then the flush held one more cycle.
    drive(C_LW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(C_SW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("stallflush_hold", 8'(bus.ALUSrc_o), 8'h01);
    drive(C_SW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_held_bubble", 8'(bus.ALUSrc_o), 8'h00);
    check("flush_held_lw_mem", 8'(bus.MemRead_o), 8'h01);
    idle(4);

    // JAL: a jump when enabled, otherwise an unknown opcode.
    drive(C_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_PIPE_JUMP_EN
    check("jal_ex_jump", 8'(bus.Jump_o), 8'h01);
    idle(2);
    check("jal_wb_link_sel",  8'(bus.LinkSel_o),  8'h01);
    check("jal_wb_reg_write", 8'(bus.RegWrite_o), 8'h01);
`else
    check("jal_illegal", 8'(bus.Illegal_o), 8'h01);
    idle(2);
    check("jal_no_regwrite", 8'(bus.RegWrite_o), 8'h00);
`endif
    idle(3);

    // Random traffic, including occasional mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 7)];
      drive(op, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 49) == 0));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
